// File: rtl/cbus_sram_responder.sv
// CBus responder backed by a word-addressed SRAM model: single and INCR/FIXED burst
// reads and writes with byte strobes, fixed request-to-first-beat latency.
module cbus_sram_responder #(
   parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
   parameter int          DEPTH     = 4096,
   parameter int          LATENCY   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        creq_valid_i,
   input  logic        creq_is_write_i,
   input  logic [2:0]  creq_size_i,
   input  logic [63:0] creq_addr_i,
   input  logic [7:0]  creq_strobe_i,
   input  logic [63:0] creq_data_i,
   input  logic [3:0]  creq_len_i,
   input  logic [1:0]  creq_burst_i,
   output logic        cresp_ready_o,
   output logic        cresp_last_o,
   output logic [63:0] cresp_data_o
);

   localparam int AW  = $clog2(DEPTH);
   localparam int WCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [1:0] BURST_FIXED = 2'b00;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BEAT} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   idx_q, idx_d;
   logic [3:0]      len_q, len_d;
   logic [3:0]      beat_cnt_q, beat_cnt_d;
   logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
   logic            is_write_q, is_write_d;
   logic            fixed_q, fixed_d;
   logic            in_range_q, in_range_d;

   logic [63:0]     offset;
   logic            addr_in_range;
   logic            mem_we;
   logic [63:0]     rd_word;
   logic            unused_bits;

   // Offsets below the base wrap to huge values, so one upper-bit test covers both ends.
   assign offset        = creq_addr_i - BASE_ADDR;
   assign addr_in_range = (creq_addr_i >= BASE_ADDR) && (offset[63:AW+3] == '0);
   assign unused_bits   = ^{creq_size_i, offset[2:0]};

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      len_d      = len_q;
      beat_cnt_d = beat_cnt_q;
      wait_cnt_d = wait_cnt_q;
      is_write_d = is_write_q;
      fixed_d    = fixed_q;
      in_range_d = in_range_q;
      case (state_q)
         S_IDLE: begin
            if (creq_valid_i) begin
               idx_d      = offset[AW+2:3];
               len_d      = creq_len_i;
               is_write_d = creq_is_write_i;
               fixed_d    = (creq_burst_i == BURST_FIXED);
               in_range_d = addr_in_range;
               beat_cnt_d = '0;
               wait_cnt_d = WCW'(LATENCY - 1);
               state_d    = (LATENCY == 1) ? S_BEAT : S_WAIT;
            end
         end
         S_WAIT: begin
            if (!creq_valid_i) begin
               state_d = S_IDLE;
            end else if (wait_cnt_q <= WCW'(1)) begin
               state_d = S_BEAT;
            end else begin
               wait_cnt_d = wait_cnt_q - WCW'(1);
            end
         end
         S_BEAT: begin
            if (!creq_valid_i || beat_cnt_q == len_q) begin
               state_d = S_IDLE;
            end else begin
               beat_cnt_d = beat_cnt_q + 4'd1;
               if (!fixed_q) begin
                  idx_d = idx_q + AW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         len_q      <= '0;
         beat_cnt_q <= '0;
         wait_cnt_q <= '0;
         is_write_q <= 1'b0;
         fixed_q    <= 1'b0;
         in_range_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         len_q      <= len_d;
         beat_cnt_q <= beat_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         is_write_q <= is_write_d;
         fixed_q    <= fixed_d;
         in_range_q <= in_range_d;
      end
   end

   // A beat with valid dropped is the abort cycle and must not touch the SRAM.
   assign mem_we = (state_q == S_BEAT) && creq_valid_i && is_write_q && in_range_q && !reset;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_lane
         logic [7:0] mem_lane [DEPTH];
         always_ff @(posedge clk) begin
            if (mem_we && creq_strobe_i[gi]) begin
               mem_lane[idx_q] <= creq_data_i[8*gi +: 8];
            end
         end
         assign rd_word[8*gi +: 8] = mem_lane[idx_q];
      end
   endgenerate

   assign cresp_ready_o = (state_q == S_BEAT);
   assign cresp_last_o  = cresp_ready_o && (beat_cnt_q == len_q);
   assign cresp_data_o  = (cresp_ready_o && !is_write_q && in_range_q) ? rd_word : 64'd0;

endmodule
